// File: rtl/shake_arbiter_if.sv
// Requester-side and SHAKE-core-side signals of the SHAKE core arbiter.
// The slave modport is the arbiter's view; master is the view of requesters plus core.
interface shake_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int W     = 32,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   rel;
  logic [N_REQ-1:0]   gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               busy;
  logic [N_REQ-1:0]   din_valid_req;
  logic [N_REQ*W-1:0] din_req;
  logic [N_REQ-1:0]   din_ready_req;
  logic [N_REQ-1:0]   dout_ready_req;
  logic [N_REQ-1:0]   dout_valid_req;
  logic [W-1:0]       dout_req;
  logic [N_REQ-1:0]   force_done_req;
  logic               din_valid_shake;
  logic [W-1:0]       din_shake;
  logic               din_ready_shake;
  logic               dout_valid_shake;
  logic               dout_ready_shake;
  logic [W-1:0]       dout_shake;
  logic               force_done_shake;

  modport slave (
    input  req, rel, din_valid_req, din_req, dout_ready_req, force_done_req,
           din_ready_shake, dout_valid_shake, dout_shake,
    output gnt, gnt_idx, busy, din_ready_req, dout_valid_req, dout_req,
           din_valid_shake, din_shake, dout_ready_shake, force_done_shake
  );

  modport master (
    output req, rel, din_valid_req, din_req, dout_ready_req, force_done_req,
           din_ready_shake, dout_valid_shake, dout_shake,
    input  gnt, gnt_idx, busy, din_ready_req, dout_valid_req, dout_req,
           din_valid_shake, din_shake, dout_ready_shake, force_done_shake
  );
endinterface

// File: rtl/shake_arbiter.sv
// Round-robin ownership arbiter for the shared keccak_top SHAKE core.
// Streams use valid/ready: a word moves on a rising edge where valid and ready are both high.
module shake_arbiter #(
  parameter int N_REQ = 2,
  parameter int W     = 32,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic       clk,
  input  logic       rst,
  shake_arbiter_if.slave bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_REL  = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [N_REQ-1:0]   gnt_q;
  logic [IDX_W-1:0]   gnt_idx_q;
  logic               busy_q;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
    int j;
    j = int'(base) + k;
    if (j >= N_REQ) j = j - N_REQ;
    return IDX_W'(j);
  endfunction

  // Scan from the highest offset down so the nearest requester at/after ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req[wrap_add(ptr, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(ptr, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            gnt_q     <= N_REQ'(1) << pick_idx;
            gnt_idx_q <= pick_idx;
            busy_q    <= 1'b1;
            state     <= S_OWN;
          end
        end
        S_OWN: begin
          if (bus.rel[gnt_idx_q]) begin
            gnt_q  <= '0;
            busy_q <= 1'b0;
            ptr    <= wrap_add(gnt_idx_q, 1);
            state  <= S_REL;
          end
        end
        S_REL:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = gnt_idx_q;
  assign bus.busy    = busy_q;
  assign bus.dout_req = bus.dout_shake;
  assign dbg_state   = state;

  // Routing is live only in OWN, so the REL gap blocks any late core handshake.
  always_comb begin
    bus.din_valid_shake  = 1'b0;
    bus.din_shake        = '0;
    bus.dout_ready_shake = 1'b0;
    bus.force_done_shake = 1'b0;
    bus.din_ready_req    = '0;
    bus.dout_valid_req   = '0;
    if (state == S_OWN) begin
      bus.din_valid_shake           = bus.din_valid_req[gnt_idx_q];
      bus.din_shake                 = bus.din_req[int'(gnt_idx_q)*W +: W];
      bus.dout_ready_shake          = bus.dout_ready_req[gnt_idx_q];
      bus.force_done_shake          = bus.force_done_req[gnt_idx_q];
      bus.din_ready_req[gnt_idx_q]  = bus.din_ready_shake;
      bus.dout_valid_req[gnt_idx_q] = bus.dout_valid_shake;
    end
  end

endmodule

// File: tb/tb_shake_arbiter.sv
// Bench for shake_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a cycle-level ownership model.
module tb_shake_arbiter;
  localparam int N = 2;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;

  shake_arbiter_if #(.N_REQ(N), .W(W)) bus();

  shake_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.req = '0;
    bus.rel = '0;
    bus.din_valid_req = '0;
    bus.din_req = '0;
    bus.dout_ready_req = '0;
    bus.force_done_req = '0;
    bus.din_ready_shake = 1'b0;
    bus.dout_valid_shake = 1'b0;
    bus.dout_shake = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // scoreboard for words accepted by the core
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_word;
  logic         sb_on = 1'b0;
  int           accepted = 0;

  always @(posedge clk) begin
    if (sb_on && rst && bus.din_valid_shake && bus.din_ready_shake) begin
      accepted++;
      if (exp_q.size() == 0) begin
        chk("core_word_unexpected", {32'd0, bus.din_shake}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_word = exp_q.pop_front();
        chk("core_word", {32'd0, bus.din_shake}, {32'd0, exp_word});
      end
    end
  end

  // directed vectors: inputs before an edge, gnt/busy after it
  typedef struct {
    logic [1:0] req;
    logic [1:0] rel;
    logic [1:0] gnt;
    logic       busy;
  } vec_t;

  vec_t vecs[15];

  // ownership model
  int owner;
  int cool;
  int prio;

  task automatic model_step();
    if (owner >= 0) begin
      if (bus.rel[owner]) begin
        prio  = (owner + 1) % N;
        owner = -1;
        cool  = 1;
      end
    end else if (cool > 0) begin
      cool--;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (owner < 0 && bus.req[(prio + k) % N]) owner = (prio + k) % N;
      end
    end
  endtask

  task automatic model_check();
    logic [N-1:0] eg;
    eg = (owner >= 0) ? N'(1 << owner) : '0;
    chk("rnd_gnt", bus.gnt, eg);
    chk("rnd_busy", bus.busy, owner >= 0);
    chk("rnd_dout_req", bus.dout_req, bus.dout_shake);
    if (owner >= 0) begin
      chk("rnd_gnt_idx", bus.gnt_idx, owner);
      chk("rnd_din_valid_shake", bus.din_valid_shake, bus.din_valid_req[owner]);
      chk("rnd_din_shake", bus.din_shake, bus.din_req[owner*W +: W]);
      chk("rnd_dout_ready_shake", bus.dout_ready_shake, bus.dout_ready_req[owner]);
      chk("rnd_force_done_shake", bus.force_done_shake, bus.force_done_req[owner]);
      chk("rnd_din_ready_req", bus.din_ready_req, N'(bus.din_ready_shake) << owner);
      chk("rnd_dout_valid_req", bus.dout_valid_req, N'(bus.dout_valid_shake) << owner);
    end else begin
      chk("rnd_idle_core_side",
          {bus.din_valid_shake, bus.dout_ready_shake, bus.force_done_shake, bus.din_shake}, '0);
      chk("rnd_idle_req_side", {bus.din_ready_req, bus.dout_valid_req}, '0);
    end
  endtask

  initial begin
    clear_inputs();
    vecs[0]  = '{2'b11, 2'b00, 2'b01, 1'b1};
    vecs[1]  = '{2'b11, 2'b10, 2'b01, 1'b1};
    vecs[2]  = '{2'b11, 2'b01, 2'b00, 1'b0};
    vecs[3]  = '{2'b11, 2'b00, 2'b00, 1'b0};
    vecs[4]  = '{2'b11, 2'b00, 2'b10, 1'b1};
    vecs[5]  = '{2'b00, 2'b01, 2'b10, 1'b1};
    vecs[6]  = '{2'b00, 2'b00, 2'b10, 1'b1};
    vecs[7]  = '{2'b11, 2'b10, 2'b00, 1'b0};
    vecs[8]  = '{2'b11, 2'b00, 2'b00, 1'b0};
    vecs[9]  = '{2'b11, 2'b00, 2'b01, 1'b1};
    vecs[10] = '{2'b01, 2'b01, 2'b00, 1'b0};
    vecs[11] = '{2'b10, 2'b00, 2'b00, 1'b0};
    vecs[12] = '{2'b00, 2'b00, 2'b00, 1'b0};
    vecs[13] = '{2'b01, 2'b00, 2'b01, 1'b1};
    vecs[14] = '{2'b00, 2'b01, 2'b00, 1'b0};

    // reset values with every input that could leak held high
    rst = 1'b0;
    bus.din_valid_req = 2'b11;
    bus.force_done_req = 2'b11;
    bus.dout_ready_req = 2'b11;
    bus.din_req = {32'hAAAA_5555, 32'h1234_5678};
    bus.din_ready_shake = 1'b1;
    bus.dout_valid_shake = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_gnt_idx", bus.gnt_idx, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_core_side", {bus.din_valid_shake, bus.dout_ready_shake, bus.force_done_shake, bus.din_shake}, 0);
    chk("rst_req_side", {bus.din_ready_req, bus.dout_valid_req}, 0);
    do_reset();

    // table-driven arbitration sequence
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus.req = vecs[i].req;
      bus.rel = vecs[i].rel;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_gnt", i), bus.gnt, vecs[i].gnt);
      chk($sformatf("vec%0d_busy", i), bus.busy, vecs[i].busy);
    end

    // single requester stream with requester 1 holding valid
    do_reset();
    sb_on = 1'b1;
    accepted = 0;
    repeat (4) @(negedge clk);
    bus.req = 2'b01;
    @(posedge clk);
    #1;
    chk("single_gnt", bus.gnt, 2'b01);
    chk("single_gnt_idx", bus.gnt_idx, 0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus.req = 2'b00;
      bus.rel = (i == 16) ? 2'b01 : 2'b00;
      bus.din_valid_req = 2'b11;
      bus.din_req = {$urandom(), $urandom()};
      bus.din_ready_shake = 1'b1;
      bus.dout_valid_shake = 1'($urandom_range(0, 1));
      bus.dout_ready_req = 2'($urandom_range(0, 3));
      bus.dout_shake = $urandom();
      exp_q.push_back(bus.din_req[31:0]);
      #1;
      chk("stream_din_shake", bus.din_shake, bus.din_req[31:0]);
      chk("stream_din_valid_shake", bus.din_valid_shake, 1);
      chk("iso_din_ready_req", bus.din_ready_req, 2'b01);
      chk("iso_dout_valid_req", bus.dout_valid_req, {1'b0, bus.dout_valid_shake});
      chk("stream_dout_ready_shake", bus.dout_ready_shake, bus.dout_ready_req[0]);
      chk("stream_dout_req", bus.dout_req, bus.dout_shake);
    end
    @(negedge clk);
    bus.rel = 2'b00;
    bus.din_req = {32'hDEAD_BEEF, 32'hBAD0_BAD0};
    #1;
    chk("rel_gnt", bus.gnt, 0);
    chk("rel_busy", bus.busy, 0);
    chk("rel_gap_din_valid_shake", bus.din_valid_shake, 0);
    chk("rel_gap_din_ready_req", bus.din_ready_req, 0);
    @(negedge clk);
    #1;
    chk("rel_idle_busy", bus.busy, 0);
    chk("accepted_count", accepted, 17);
    chk("sb_empty", exp_q.size(), 0);
    sb_on = 1'b0;
    clear_inputs();

    // owner drops req; ownership must persist
    @(negedge clk);
    bus.req = 2'b01;
    @(negedge clk);
    bus.req = 2'b00;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("hold_gnt", bus.gnt, 2'b01);
    end
    bus.rel = 2'b01;
    @(negedge clk);
    bus.rel = 2'b00;
    repeat (2) @(negedge clk);

    // pointer now at 1; grant 1, then reset mid-stream
    bus.req = 2'b11;
    @(posedge clk);
    #1;
    chk("rr_ptr1_gnt", bus.gnt, 2'b10);
    @(negedge clk);
    bus.din_valid_req = 2'b10;
    bus.force_done_req = 2'b10;
    bus.din_ready_shake = 1'b1;
    #1;
    chk("mid_din_valid_shake", bus.din_valid_shake, 1);
    chk("mid_force_done_shake", bus.force_done_shake, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_gnt", bus.gnt, 0);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_din_valid_shake", bus.din_valid_shake, 0);
    chk("async_rst_force_done_shake", bus.force_done_shake, 0);
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    bus.req = 2'b11;
    @(posedge clk);
    #1;
    chk("post_rst_gnt", bus.gnt, 2'b01);

    // randomized traffic against the model
    do_reset();
    owner = -1;
    cool  = 0;
    prio  = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.req = 2'($urandom_range(0, 3));
      bus.rel = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus.din_valid_req = 2'($urandom_range(0, 3));
      bus.din_req = {$urandom(), $urandom()};
      bus.dout_ready_req = 2'($urandom_range(0, 3));
      bus.force_done_req = 2'($urandom_range(0, 3));
      bus.din_ready_shake = 1'($urandom_range(0, 1));
      bus.dout_valid_shake = 1'($urandom_range(0, 1));
      bus.dout_shake = $urandom();
      #1;
      model_check();
      @(posedge clk);
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shake_arbiter.md
# shake_arbiter

Arbiter that shares the single `keccak_top` SHAKE core between several requesters in the encapsulation datapath, for example fixed-weight error generation and session-key/C1 hashing. Each requester wins ownership of the core with a req/gnt handshake. It holds ownership for a whole hash transaction, then hands it back with a release pulse. While a requester owns the core, the arbiter routes that requester's din/dout/force_done streams to the core and isolates every other requester. Arbitration is round-robin, so no requester is starved.

## Interface
Parameters:
- N_REQ, 2, number of requesters (2..4).
- W, 32, SHAKE data word width.
- IDX_W, `CLOG2(N_REQ) (1 minimum), grant index width.

Ports (clock and reset first):
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  N_REQ  level request, one bit per requester.
- rel  input  N_REQ  release pulse; valid only from the current owner.
- gnt  output  N_REQ  one-hot ownership, registered.
- gnt_idx  output  IDX_W  index of the current owner, registered.
- busy  output  1  high while any requester owns the core.
- din_valid_req  input  N_REQ  per-requester input valid.
- din_req  input  N_REQ*W  per-requester input data; requester i occupies bits [i*W +: W].
- din_ready_req  output  N_REQ  per-requester input ready.
- dout_ready_req  input  N_REQ  per-requester output ready.
- dout_valid_req  output  N_REQ  per-requester output valid.
- dout_req  output  W  output data, broadcast to all requesters.
- force_done_req  input  N_REQ  per-requester force_done.
- din_valid_shake  output  1  to core din_valid.
- din_shake  output  W  to core din.
- din_ready_shake  input  1  from core din_ready.
- dout_valid_shake  input  1  from core dout_valid.
- dout_ready_shake  output  1  to core dout_ready.
- dout_shake  input  W  from core dout.
- force_done_shake  output  1  to core force_done.

## Operation
- FSM states: IDLE, OWN, REL.
- IDLE:
  - If any req bit is high, pick the first requesting index at or after pointer ptr, wrapping modulo N_REQ.
  - Register gnt (one-hot), gnt_idx and busy=1, then go to OWN.
  - If no req bit is high, stay in IDLE.
- OWN, with owner o = gnt_idx:
  - din_valid_shake = din_valid_req[o].
  - din_shake = din_req[o].
  - dout_ready_shake = dout_ready_req[o].
  - force_done_shake = force_done_req[o].
  - din_ready_req[o] = din_ready_shake; dout_valid_req[o] = dout_valid_shake.
  - Every non-owner sees din_ready_req=0 and dout_valid_req=0.
  - dout_req = dout_shake in all states.
  - rel[o]=1: go to REL, clear gnt and busy, set ptr = (o+1) mod N_REQ.
- REL: lasts exactly one cycle with all muxed outputs forced to 0, then returns to IDLE. This gap keeps a late core handshake from reaching the next owner.
- Outside OWN, din_valid_shake, dout_ready_shake and force_done_shake are 0.
- A requester that drops req while it owns the core keeps ownership. Only rel ends ownership.
- rel from a non-owner is ignored, in any state.
- A handshake in the same cycle as rel[o] completes normally, because routing is still active in the rel cycle.
- req bits are sampled only in IDLE. A req that rises in OWN or REL waits for the next IDLE evaluation.
- A requester can win back-to-back only when no other requester is asserting req.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, ptr=0, gnt=0, gnt_idx=0, busy=0. All muxed outputs to the core and to the requesters are 0.
- Grant latency:
  - req rises at cycle c while in IDLE; gnt is high from cycle c+1.
  - The first data transfer can happen at cycle c+1.
- Release latency:
  - rel sampled at cycle r; gnt=0 from r+1 (REL), IDLE at r+2.
  - Earliest next grant is r+3.
  - Best-case gap between owners is 2 cycles with no core access.
- All stream muxing is combinational, selected by the registered gnt_idx. There is no added pipeline latency on din or dout.
- If reset asserts mid-transaction, ownership is dropped immediately and all outputs go to 0. The core must be reset by the same rst.
- Power-on, and after reset, the priority order starts at index 0.

## Test plan
- Single requester: after reset, req=2'b01 at cycle 5.
  - Require gnt=2'b01 at cycle 6.
  - Stream 16 seed words; require din_shake to equal din_req[31:0] word-for-word.
  - dout words go only to requester 0 via dout_valid_req[0].
  - rel at cycle 30: gnt=0 at 31, IDLE at 32.
- Simultaneous requests: req=2'b11 from IDLE with ptr=0.
  - Require gnt=2'b01.
  - After rel[0], require gnt=2'b10 three cycles later.
  - After rel[1], with req still 2'b11, require gnt=2'b01 again (round-robin).
- Isolation: requester 1 holds din_valid_req[1]=1 while requester 0 owns the core.
  - Require din_ready_req[1]=0 and dout_valid_req[1]=0 throughout.
  - Require din_valid_shake to follow requester 0 only.
- Illegal release: rel[1] pulses while requester 0 owns the core → gnt stays 2'b01, no state change.
- Owner drops req without rel → gnt unchanged for 100 cycles.
- Handshake at release, and reset:
  - A din handshake in the rel cycle is accepted by the core exactly once.
  - Assert rst=0 mid-stream: gnt, busy, din_valid_shake and force_done_shake go to 0 immediately.
  - After reset, the first grant uses ptr=0.
